// File: rtl/lif_sched_pkg.sv
// -----------------------------------------------------------------------------
// lif_sched_pkg
// Shared definitions for the time-multiplexed LIF neuron scheduler:
//   - lif_state_e : sweep controller states
//   - DEF_*       : default parameter values for the scheduler and update rule
//   - idx_width() : bits needed to index n items (minimum 1)
// -----------------------------------------------------------------------------
package lif_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_READ    = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4
    } lif_state_e;

    localparam int DEF_N_NEURONS  = 32'sd4;
    localparam int DEF_W          = 32'sd8;
    localparam int DEF_THRESHOLD  = 32'sd200;
    localparam int DEF_LEAK_SHIFT = 32'sd3;
    localparam int DEF_REFRAC     = 32'sd2;

    // Smallest width that can hold values 0..n-1; never below one bit so that
    // degenerate sizes still produce legal vectors.
    function automatic int idx_width(input int n);
        int w;
        w = 32'sd1;
        while ((32'sd1 << w) < n) begin
            w = w + 32'sd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/lif_neuron_scheduler_update.sv
// -----------------------------------------------------------------------------
// lif_update
// Purely combinational leaky-integrate-and-fire rule for one neuron.
//   i_v      : stored membrane potential
//   i_i      : synaptic current for this sweep
//   i_refrac : remaining refractory sweeps
//   o_v      : new membrane potential
//   o_refrac : new refractory count
//   o_spike  : neuron fires this sweep
// -----------------------------------------------------------------------------
module lif_update
    import lif_sched_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int THRESHOLD  = DEF_THRESHOLD,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
    parameter int REFRAC     = DEF_REFRAC,
    parameter int RW         = idx_width(DEF_REFRAC + 32'sd1)
)(
    input  logic [W-1:0]  i_v,
    input  logic [W-1:0]  i_i,
    input  logic [RW-1:0] i_refrac,
    output logic [W-1:0]  o_v,
    output logic [RW-1:0] o_refrac,
    output logic          o_spike
);

    localparam logic [W:0]    THRESH_EXT  = (W+1)'(THRESHOLD);
    localparam logic [RW-1:0] REFRAC_LOAD = RW'(REFRAC);

    logic [W-1:0] w_leak;
    logic [W:0]   w_sum;
    logic [W-1:0] w_sat;

    // Leak, integrate and saturate; one extra bit catches V - leak + I overflow.
    always_comb begin
        w_leak = i_v >> LEAK_SHIFT;
        w_sum  = {1'b0, i_v} - {1'b0, w_leak} + {1'b0, i_i};
        if (w_sum[W]) begin
            w_sat = {W{1'b1}};
        end else begin
            w_sat = w_sum[W-1:0];
        end
    end

    // Refractory neurons are clamped to zero and ignore input; otherwise fire
    // on the saturated sum reaching threshold.
    always_comb begin
        o_v      = w_sat;
        o_refrac = {RW{1'b0}};
        o_spike  = 1'b0;
        if (i_refrac != {RW{1'b0}}) begin
            o_v      = {W{1'b0}};
            o_refrac = i_refrac - RW'(1);
            o_spike  = 1'b0;
        end else if ({1'b0, w_sat} >= THRESH_EXT) begin
            o_v      = {W{1'b0}};
            o_refrac = REFRAC_LOAD;
            o_spike  = 1'b1;
        end else begin
            o_v      = w_sat;
            o_refrac = {RW{1'b0}};
            o_spike  = 1'b0;
        end
    end

endmodule

// File: rtl/lif_neuron_scheduler.sv
// -----------------------------------------------------------------------------
// lif_neuron_scheduler
// Shares one LIF update datapath across N_NEURONS virtual neurons. Each
// accepted tick runs one sweep: capture the synaptic bus, then READ/WRITE each
// neuron in index order, then publish the spike vector.
//   clk, reset  : clock, synchronous active-high reset
//   tick_valid  : sweep request; tick_ready is high only in IDLE
//   i_syn_bus   : synaptic currents, neuron k at [k*W +: W]
//   v_valid     : one-cycle strobe with v_idx / v_mem_out per neuron update
//   spike_vec   : spikes of the last completed sweep
//   sweep_done  : one-cycle pulse when spike_vec is refreshed
//   overrun     : sticky, a tick arrived while a sweep was in progress
// -----------------------------------------------------------------------------
module lif_neuron_scheduler
    import lif_sched_pkg::*;
#(
    parameter int N_NEURONS  = DEF_N_NEURONS,
    parameter int W          = DEF_W,
    parameter int THRESHOLD  = DEF_THRESHOLD,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
    parameter int REFRAC     = DEF_REFRAC
)(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           tick_valid,
    output logic                           tick_ready,
    input  logic [N_NEURONS*W-1:0]         i_syn_bus,
    output logic                           v_valid,
    output logic [idx_width(N_NEURONS)-1:0] v_idx,
    output logic [W-1:0]                   v_mem_out,
    output logic [N_NEURONS-1:0]           spike_vec,
    output logic                           sweep_done,
    output logic                           overrun
);

    localparam int IDX_W = idx_width(N_NEURONS);
    localparam int RW    = idx_width(REFRAC + 32'sd1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 32'sd1);

    lif_state_e         r_state;
    lif_state_e         w_state_next;
    logic [IDX_W-1:0]   r_idx;

    logic [W-1:0]       r_syn    [N_NEURONS];
    logic [W-1:0]       r_v_mem  [N_NEURONS];
    logic [RW-1:0]      r_refrac [N_NEURONS];

    logic [W-1:0]       r_rd_v;
    logic [W-1:0]       r_rd_i;
    logic [RW-1:0]      r_rd_refrac;

    logic [N_NEURONS-1:0] r_shadow;
    logic [N_NEURONS-1:0] r_spike_vec;
    logic                 r_sweep_done;
    logic                 r_v_valid;
    logic [IDX_W-1:0]     r_v_idx;
    logic [W-1:0]         r_v_mem_out;
    logic                 r_overrun;

    logic [W-1:0]       w_new_v;
    logic [RW-1:0]      w_new_refrac;
    logic               w_spike;

    lif_update #(
        .W          (W),
        .THRESHOLD  (THRESHOLD),
        .LEAK_SHIFT (LEAK_SHIFT),
        .REFRAC     (REFRAC),
        .RW         (RW)
    ) u_update (
        .i_v      (r_rd_v),
        .i_i      (r_rd_i),
        .i_refrac (r_rd_refrac),
        .o_v      (w_new_v),
        .o_refrac (w_new_refrac),
        .o_spike  (w_spike)
    );

    // Sweep sequencing: capture, alternate READ/WRITE per neuron, then publish.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (tick_valid) begin
                    w_state_next = ST_CAPTURE;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_CAPTURE: w_state_next = ST_READ;
            ST_READ:    w_state_next = ST_WRITE;
            ST_WRITE: begin
                if (r_idx == LAST_IDX) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_READ;
                end
            end
            ST_DONE:    w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // State, neuron storage, datapath pipeline registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_idx        <= {IDX_W{1'b0}};
            r_rd_v       <= {W{1'b0}};
            r_rd_i       <= {W{1'b0}};
            r_rd_refrac  <= {RW{1'b0}};
            r_shadow     <= {N_NEURONS{1'b0}};
            r_spike_vec  <= {N_NEURONS{1'b0}};
            r_sweep_done <= 1'b0;
            r_v_valid    <= 1'b0;
            r_v_idx      <= {IDX_W{1'b0}};
            r_v_mem_out  <= {W{1'b0}};
            r_overrun    <= 1'b0;
            for (int k = 0; k < N_NEURONS; k++) begin
                r_syn[k]    <= {W{1'b0}};
                r_v_mem[k]  <= {W{1'b0}};
                r_refrac[k] <= {RW{1'b0}};
            end
        end else begin
            r_state      <= w_state_next;
            r_v_valid    <= 1'b0;
            r_sweep_done <= 1'b0;
            // Ticks are not queued; a busy request only leaves a sticky mark.
            if (tick_valid && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end else begin
                r_overrun <= r_overrun;
            end
            case (r_state)
                ST_IDLE: begin
                    r_idx <= {IDX_W{1'b0}};
                end
                ST_CAPTURE: begin
                    // Freeze the bus so later input changes cannot leak into this sweep.
                    for (int k = 0; k < N_NEURONS; k++) begin
                        r_syn[k] <= i_syn_bus[k*W +: W];
                    end
                    r_shadow <= {N_NEURONS{1'b0}};
                    r_idx    <= {IDX_W{1'b0}};
                end
                ST_READ: begin
                    r_rd_v      <= r_v_mem[r_idx];
                    r_rd_i      <= r_syn[r_idx];
                    r_rd_refrac <= r_refrac[r_idx];
                end
                ST_WRITE: begin
                    r_v_mem[r_idx]  <= w_new_v;
                    r_refrac[r_idx] <= w_new_refrac;
                    r_shadow[r_idx] <= w_spike;
                    r_v_valid       <= 1'b1;
                    r_v_idx         <= r_idx;
                    r_v_mem_out     <= w_new_v;
                    if (r_idx != LAST_IDX) begin
                        r_idx <= r_idx + IDX_W'(1);
                    end else begin
                        r_idx <= r_idx;
                    end
                end
                ST_DONE: begin
                    // Spikes become visible together, only once the sweep is complete.
                    r_spike_vec  <= r_shadow;
                    r_sweep_done <= 1'b1;
                end
                default: begin
                    r_idx <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    assign tick_ready = (r_state == ST_IDLE);
    assign v_valid    = r_v_valid;
    assign v_idx      = r_v_idx;
    assign v_mem_out  = r_v_mem_out;
    assign spike_vec  = r_spike_vec;
    assign sweep_done = r_sweep_done;
    assign overrun    = r_overrun;

endmodule
